// File: rtl/pwm_fade_ctrl_if.sv
// rtl/pwm_fade_ctrl_if.sv - fade controller bus: run/period inputs, duty outputs
// The master side is the controller's user, the slave side is pwm_fade_ctrl.
interface pwm_fade_ctrl_if;
  logic       enable;
  logic       period_end;
  logic [7:0] duty_cycle;
  logic       duty_valid;
  logic       ramp_up;

  modport master (
    output enable,
    output period_end,
    input  duty_cycle,
    input  duty_valid,
    input  ramp_up
  );

  modport slave (
    input  enable,
    input  period_end,
    output duty_cycle,
    output duty_valid,
    output ramp_up
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - triangular duty-cycle fader feeding a downstream PWM stage
// Target duty ramps between DUTY_MIN and DUTY_MAX on prescaler ticks; output only reloads at PWM period ends.
module pwm_fade_ctrl #(
  parameter int TICK_DIV   = 270000,
  parameter int STEP       = 1,
  parameter int DUTY_MIN   = 0,
  parameter int DUTY_MAX   = 255,
  parameter int HOLD_TICKS = 50
) (
  input  logic          clk,
  input  logic          rstn,
  pwm_fade_ctrl_if.slave bus
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]     DMIN      = 8'(DUTY_MIN);
  localparam logic [7:0]     DMAX      = 8'(DUTY_MAX);
  localparam logic [7:0]     STEP8     = 8'(STEP);
  localparam logic [7:0]     HOLD8     = 8'(HOLD_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    duty_q, duty_d;
  logic          valid_q, valid_d;
  logic          ramp_up_q, ramp_up_d;

  logic          tick;
  logic [8:0]    up_sum;
  logic [8:0]    hold_next;

  always_comb begin
    tick      = (state_q != IDLE) && (presc_q == TICK_LAST);
    up_sum    = {1'b0, target_q} + {1'b0, STEP8};
    hold_next = {1'b0, hold_q} + 9'd1;

    state_d  = state_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    target_d = target_q;

    // IDLE, or a drop of enable anywhere, parks everything at its start value.
    if ((state_q == IDLE) || !bus.enable) begin
      state_d  = bus.enable ? RAMP_UP : IDLE;
      presc_d  = '0;
      hold_d   = '0;
      target_d = DMIN;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        case (state_q)
          RAMP_UP: begin
            if (up_sum >= {1'b0, DMAX}) begin
              target_d = DMAX;
              hold_d   = '0;
              state_d  = HOLD_HIGH;
            end else begin
              target_d = up_sum[7:0];
            end
          end
          HOLD_HIGH: begin
            if (hold_next >= {1'b0, HOLD8}) state_d = RAMP_DOWN;
            else                            hold_d  = hold_next[7:0];
          end
          RAMP_DOWN: begin
            if ({1'b0, target_q} <= ({1'b0, DMIN} + {1'b0, STEP8})) begin
              target_d = DMIN;
              hold_d   = '0;
              state_d  = HOLD_LOW;
            end else begin
              target_d = target_q - STEP8;
            end
          end
          HOLD_LOW: begin
            if (hold_next >= {1'b0, HOLD8}) state_d = RAMP_UP;
            else                            hold_d  = hold_next[7:0];
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Output sees the pre-update target, so a coincident tick shows up one period later.
    duty_d    = bus.period_end ? target_q : duty_q;
    valid_d   = bus.period_end && (target_q != duty_q);
    ramp_up_d = (state_d == RAMP_UP) || (state_d == HOLD_HIGH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      hold_q    <= '0;
      target_q  <= DMIN;
      duty_q    <= DMIN;
      valid_q   <= 1'b0;
      ramp_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      ramp_up_q <= ramp_up_d;
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.ramp_up    = ramp_up_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - scoreboard bench for pwm_fade_ctrl
// u_dut uses HOLD_TICKS=1, u_dut0 uses HOLD_TICKS=0; expected duty events carry the edge they must appear on.
module tb_pwm_fade_ctrl;

  typedef struct {
    logic [7:0] duty;
    logic       ramp;
    int         at_cyc;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc       = 0;
  int   checks    = 0;
  int   failures  = 0;
  int   base      = 0;
  int   base0     = 0;
  int   pe_period = 0;
  int   pe_phase  = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] prev_duty [2];

  pwm_fade_ctrl_if if_a ();
  pwm_fade_ctrl_if if_b ();

  pwm_fade_ctrl #(
    .TICK_DIV(4), .STEP(100), .DUTY_MIN(0), .DUTY_MAX(255), .HOLD_TICKS(1)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (if_a)
  );

  pwm_fade_ctrl #(
    .TICK_DIV(4), .STEP(100), .DUTY_MIN(0), .DUTY_MAX(255), .HOLD_TICKS(0)
  ) u_dut0 (
    .clk (clk),
    .rstn(rstn),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input logic [7:0] d, input logic r, input int c);
    exp_t e;
    e.duty   = d;
    e.ramp   = r;
    e.at_cyc = c;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic mon_one(input int id, input logic v, input logic [7:0] d, input logic r);
    exp_t e;
    int   qs;
    if (!rstn) begin
      prev_duty[id] = d;
      return;
    end
    qs = (id == 0) ? q0.size() : q1.size();
    if (v) begin
      checks++;
      if (qs == 0) begin
        failures++;
        $display("FAIL dut%0d_unexpected_valid actual duty=%0d cyc=%0d, no event expected", id, d, cyc);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (d !== e.duty || r !== e.ramp || cyc != e.at_cyc) begin
          failures++;
          $display("FAIL dut%0d_duty_event actual duty=%0d ramp=%0b cyc=%0d expected duty=%0d ramp=%0b cyc=%0d",
                   id, d, r, cyc, e.duty, e.ramp, e.at_cyc);
        end
      end
    end else if (d !== prev_duty[id]) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_silent_change actual duty=%0d prev=%0d without duty_valid", id, d, prev_duty[id]);
    end
    prev_duty[id] = d;
  endtask

  always @(negedge clk) begin
    mon_one(0, if_a.duty_valid, if_a.duty_cycle, if_a.ramp_up);
    mon_one(1, if_b.duty_valid, if_b.duty_cycle, if_b.ramp_up);
  end

  // Drives period_end for the upcoming edge; called just after a negedge.
  task automatic drive_pe();
    int off;
    off = cyc + 1 - base;
    if (pe_period == 1)      if_a.period_end = 1'b1;
    else if (pe_period == 0) if_a.period_end = 1'b0;
    else                     if_a.period_end = (off >= 0) && ((off % pe_period) == pe_phase);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(negedge clk);
      drive_pe();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_duty[0]    = 8'd0;
    prev_duty[1]    = 8'd0;
    rstn            = 1'b0;
    if_a.enable     = 1'b0;
    if_a.period_end = 1'b0;
    if_b.enable     = 1'b0;
    if_b.period_end = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_duty", if_a.duty_cycle, 0);
    chk("rst_valid", if_a.duty_valid, 0);
    chk("rst_ramp", if_a.ramp_up, 0);
    rstn = 1'b1;

    // Full up/hold/down/hold cycle with period_end every cycle.
    @(negedge clk);
    pe_period   = 1;
    if_a.enable = 1'b1;
    base        = cyc + 1;
    drive_pe();
    push(0, 8'd100, 1'b1, base + 5);
    push(0, 8'd200, 1'b1, base + 9);
    push(0, 8'd255, 1'b1, base + 13);
    push(0, 8'd155, 1'b0, base + 21);
    push(0, 8'd55,  1'b0, base + 25);
    push(0, 8'd0,   1'b0, base + 29);
    push(0, 8'd100, 1'b1, base + 37);
    push(0, 8'd200, 1'b1, base + 41);
    wait_edge(base + 41);

    // Drop enable at duty 200, then re-enable from IDLE.
    if_a.enable = 1'b0;
    push(0, 8'd0, 1'b0, base + 43);
    wait_edge(base + 42);
    chk("disable_ramp", if_a.ramp_up, 0);
    chk("disable_duty_hold", if_a.duty_cycle, 200);
    wait_edge(base + 46);
    if_a.enable = 1'b1;
    base        = cyc + 1;
    drive_pe();
    push(0, 8'd100, 1'b1, base + 5);
    push(0, 8'd200, 1'b1, base + 9);
    push(0, 8'd255, 1'b1, base + 13);
    push(0, 8'd155, 1'b0, base + 21);
    wait_edge(base + 22);

    // Asynchronous reset in RAMP_DOWN, away from any clock edge.
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_duty", if_a.duty_cycle, 0);
    chk("async_rst_valid", if_a.duty_valid, 0);
    chk("async_rst_ramp", if_a.ramp_up, 0);
    chk("q0_drained_before_rst", q0.size(), 0);
    @(negedge clk);
    base      = cyc + 1;
    pe_period = 10;
    pe_phase  = 8;
    drive_pe();
    #2;
    rstn = 1'b1;

    // Sparse period_end: first one coincides with the 100->200 tick; 200 is skipped.
    push(0, 8'd100, 1'b1, base + 8);
    push(0, 8'd255, 1'b0, base + 18);
    push(0, 8'd55,  1'b0, base + 28);
    push(0, 8'd100, 1'b1, base + 38);
    wait_edge(base + 40);
    pe_period       = 0;
    if_a.period_end = 1'b0;
    chk("q0_drained_sparse", q0.size(), 0);

    // HOLD_TICKS=0 instance: one tick at each limit, period_end every cycle.
    @(negedge clk);
    if_b.enable = 1'b1;
    base0       = cyc + 1;
    push(1, 8'd100, 1'b1, base0 + 5);
    push(1, 8'd200, 1'b1, base0 + 9);
    push(1, 8'd255, 1'b1, base0 + 13);
    push(1, 8'd155, 1'b0, base0 + 21);
    push(1, 8'd55,  1'b0, base0 + 25);
    push(1, 8'd0,   1'b0, base0 + 29);
    push(1, 8'd100, 1'b1, base0 + 37);
    wait_edge(base0 + 40);
    chk("q1_drained", q1.size(), 0);
    chk("q0_quiet", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
